// File: rtl/pipeline_stall_controller_if.sv
// Hazard/busy inputs and stage-control outputs between the stall controller and the Otter pipeline.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             load_use_haz;
    logic             control_haz;
    logic             imem_busy;
    logic             dmem_busy;
    logic             pc_we;
    logic             if_de_we;
    logic             de_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_de_flush;
    logic             de_ex_flush;
    logic             stall_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  load_use_haz, control_haz, imem_busy, dmem_busy,
        output pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
        output if_de_flush, de_ex_flush, stall_err, stall_cnt, flush_cnt
    );

    modport slave (
        output load_use_haz, control_haz, imem_busy, dmem_busy,
        input  pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
        input  if_de_flush, de_ex_flush, stall_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stage enable/flush sequencer for the 5-stage Otter pipeline; zero-latency outputs from state+inputs.
// A data-memory stall freezes every stage; a wrong-path fetch is drained through DISCARD.
module pipeline_stall_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                         CLK,
    input  logic                         RST,
    pipeline_stall_controller_if.master  bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DISCARD = 2'd1
    } state_t;

    localparam logic [15:0] TIMEOUT_V = TIMEOUT[15:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [15:0]      r_frz_cnt;
    logic [15:0]      w_frz_nxt;
    logic             r_stall_err;

    logic w_pc_we;
    logic w_if_de_we;
    logic w_de_ex_we;
    logic w_ex_mem_we;
    logic w_mem_wb_we;
    logic w_if_de_flush;
    logic w_de_ex_flush;
    logic w_redirect;

    always_comb begin
        w_pc_we       = 1'b1;
        w_if_de_we    = 1'b1;
        w_de_ex_we    = 1'b1;
        w_ex_mem_we   = 1'b1;
        w_mem_wb_we   = 1'b1;
        w_if_de_flush = 1'b0;
        w_de_ex_flush = 1'b0;
        w_redirect    = 1'b0;
        w_state_nxt   = ST_RUN;
        if (RST) begin
            w_pc_we       = 1'b0;
            w_if_de_flush = 1'b1;
            w_de_ex_flush = 1'b1;
        end else if (bus.dmem_busy) begin
            w_pc_we     = 1'b0;
            w_if_de_we  = 1'b0;
            w_de_ex_we  = 1'b0;
            w_ex_mem_we = 1'b0;
            w_mem_wb_we = 1'b0;
            w_state_nxt = (r_state == ST_DISCARD) ? ST_DISCARD : ST_RUN;
        end else begin
            case (r_state)
                ST_DISCARD: begin
                    w_pc_we       = 1'b0;
                    w_if_de_flush = 1'b1;
                    w_state_nxt   = bus.imem_busy ? ST_DISCARD : ST_RUN;
                end
                default: begin
                    // A taken branch leaves the old fetch in flight when imem is still busy
                    if (bus.control_haz) begin
                        w_if_de_flush = 1'b1;
                        w_de_ex_flush = 1'b1;
                        w_redirect    = 1'b1;
                        w_state_nxt   = bus.imem_busy ? ST_DISCARD : ST_RUN;
                    end else if (bus.load_use_haz) begin
                        w_pc_we       = 1'b0;
                        w_if_de_we    = 1'b0;
                        w_de_ex_flush = 1'b1;
                    end else if (bus.imem_busy) begin
                        w_pc_we       = 1'b0;
                        w_if_de_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_frz_nxt = (&r_frz_cnt) ? r_frz_cnt : r_frz_cnt + 16'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_frz_cnt   <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_pc_we && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (bus.dmem_busy) begin
                r_frz_cnt <= w_frz_nxt;
                if (w_frz_nxt == TIMEOUT_V) begin
                    r_stall_err <= 1'b1;
                end
            end else begin
                r_frz_cnt <= '0;
            end
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.if_de_we    = w_if_de_we;
    assign bus.de_ex_we    = w_de_ex_we;
    assign bus.ex_mem_we   = w_ex_mem_we;
    assign bus.mem_wb_we   = w_mem_wb_we;
    assign bus.if_de_flush = w_if_de_flush;
    assign bus.de_ex_flush = w_de_ex_flush;
    assign bus.stall_err   = r_stall_err;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: per-cycle behavioural model plus directed literal checks.
module tb_pipeline_stall_controller;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus();

    pipeline_stall_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // model: wrong-path flag, raw event counts, consecutive busy run, sticky error
    bit m_disc = 1'b0;
    int m_stall = 0;
    int m_flush = 0;
    int m_run = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, if_de_flush, de_ex_flush}
    function automatic logic [6:0] model_ctl();
        if (RST)                   return 7'b0111111;
        if (bus.dmem_busy)         return 7'b0000000;
        if (m_disc)                return 7'b0111110;
        if (bus.control_haz)       return 7'b1111111;
        if (bus.load_use_haz)      return 7'b0011101;
        if (bus.imem_busy)         return 7'b0111110;
        return 7'b1111100;
    endfunction

    logic [6:0] act_ctl;
    assign act_ctl = {bus.pc_we, bus.if_de_we, bus.de_ex_we, bus.ex_mem_we,
                      bus.mem_wb_we, bus.if_de_flush, bus.de_ex_flush};

    always @(negedge CLK) begin
        logic [6:0] e;
        e = model_ctl();
        chk("ctl", 32'(act_ctl), 32'(e));
        chk("stall_err", 32'(bus.stall_err), 32'(m_err));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(sat(m_stall)));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(sat(m_flush)));
        if (RST) begin
            m_disc = 1'b0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 1'b0;
        end else begin
            if (!e[6]) m_stall++;
            if (!bus.dmem_busy) begin
                if (m_disc) begin
                    m_disc = bus.imem_busy;
                end else if (bus.control_haz) begin
                    m_flush++;
                    m_disc = bus.imem_busy;
                end
            end
            m_run = bus.dmem_busy ? m_run + 1 : 0;
            if (m_run >= TIMEOUT) m_err = 1'b1;
        end
    end

    task automatic drive(input logic r, input logic l, input logic c, input logic i, input logic d);
        @(posedge CLK);
        #1;
        RST = r;
        bus.load_use_haz = l;
        bus.control_haz  = c;
        bus.imem_busy    = i;
        bus.dmem_busy    = d;
        #2;
    endtask

    initial begin
        bus.load_use_haz = 1'b0;
        bus.control_haz  = 1'b0;
        bus.imem_busy    = 1'b0;
        bus.dmem_busy    = 1'b0;

        // reset hold and release
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("rst_ctl", 32'(act_ctl), 32'h3F);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(bus.flush_cnt), 0);
        drive(0, 0, 0, 0, 0);
        chk("idle_ctl", 32'(act_ctl), 32'h7C);

        // single load-use bubble
        drive(0, 1, 0, 0, 0);
        chk("lu_ctl", 32'(act_ctl), 32'h1D);
        drive(0, 0, 0, 0, 0);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 1);

        // branch with fetch in flight, then drain
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        chk("br_ctl", 32'(act_ctl), 32'h7F);
        drive(0, 0, 0, 1, 0);
        chk("disc1_ctl", 32'(act_ctl), 32'h3E);
        drive(0, 0, 0, 1, 0);
        chk("disc2_ctl", 32'(act_ctl), 32'h3E);
        drive(0, 0, 0, 0, 0);
        chk("disc3_ctl", 32'(act_ctl), 32'h3E);
        drive(0, 0, 0, 0, 0);
        chk("br_run_ctl", 32'(act_ctl), 32'h7C);
        chk("br_flush_cnt", 32'(bus.flush_cnt), 1);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 3);

        // freeze over a pending redirect, timeout at 4 busy cycles
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 1);
            chk("frz_ctl", 32'(act_ctl), 0);
        end
        chk("frz_err_3", 32'(bus.stall_err), 0);
        chk("frz_flush_cnt", 32'(bus.flush_cnt), 0);
        drive(0, 0, 1, 0, 0);
        chk("redir_ctl", 32'(act_ctl), 32'h7F);
        chk("frz_err_4", 32'(bus.stall_err), 1);
        drive(0, 0, 0, 0, 0);
        chk("redir_flush_cnt", 32'(bus.flush_cnt), 1);
        chk("frz_stall_cnt", 32'(bus.stall_cnt), 4);
        drive(0, 0, 0, 0, 0);
        chk("err_sticky", 32'(bus.stall_err), 1);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("err_cleared", 32'(bus.stall_err), 0);

        // saturation of the stall counter
        for (int k = 0; k < 9; k++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 7);

        // reset while draining a wrong-path fetch
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("rst_disc_ctl", 32'(act_ctl), 32'h7C);
        chk("rst_disc_flush", 32'(bus.flush_cnt), 0);
        chk("rst_disc_stall", 32'(bus.stall_cnt), 0);

        // reset mid-freeze restarts the timeout count
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("rst_frz_err", 32'(bus.stall_err), 0);
        drive(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
